// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared size encodings, LSU state type and lane-offset helper
package cpu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } lsu_state_t;

    // Byte lane actually used: halves and words drop the low bits that would be misaligned.
    function automatic logic [1:0] lane_off(input logic [1:0] addr_lo, input logic [1:0] size);
        logic [1:0] off;
        case (size)
            SZ_H:    off = {addr_lo[1], 1'b0};
            SZ_W:    off = 2'b00;
            default: off = addr_lo;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - request, response and memory port bundle of the load/store unit
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_we, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_we, mem_be, mem_wdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - picks the addressed lane out of a read word and sign/zero-extends it
module lsu_align
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);
    logic [7:0]  b_lane;
    logic [15:0] h_lane;

    always_comb begin
        data   = '0;
        b_lane = rdata[{off, 3'b000} +: 8];
        h_lane = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    data = is_unsigned ? {24'h0, b_lane} : {{24{b_lane[7]}}, b_lane};
            SZ_H:    data = is_unsigned ? {16'h0, h_lane} : {{16{h_lane[15]}}, h_lane};
            SZ_W:    data = rdata;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit; LSU_MISALIGN_TRAP_EN enables alignment traps
module lsu
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 10
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);
    lsu_state_t        state, state_nxt;
    logic              r_we;
    logic              r_uns;
    logic [1:0]        r_size;
    logic [MEM_AW+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [1:0]        off;
    logic              misalign;
    logic              err;
    logic              accept;
    logic              store_access;
    logic [3:0]        be_pat;
    logic [31:0]       ld_data;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:MEM_AW+2];

    assign accept = bus.req_valid && (state == IDLE);
    assign off    = lane_off(r_addr[1:0], r_size);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((r_size == SZ_H) && r_addr[0]) ||
                      ((r_size == SZ_W) && (r_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign err = (r_size == SZ_R) || misalign;

    // Gating with rst_n keeps a store that is being reset in ACCESS from reaching memory.
    assign store_access = (state == ACCESS) && r_we && !err && rst_n;

    always_comb begin
        be_pat = 4'b0000;
        case (r_size)
            SZ_B:    be_pat = 4'b0001 << off;
            SZ_H:    be_pat = 4'b0011 << off;
            SZ_W:    be_pat = 4'b1111;
            default: be_pat = 4'b0000;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.mem_addr   = r_addr[MEM_AW+1:2];
    assign bus.mem_we     = store_access;
    assign bus.mem_be     = store_access ? be_pat : 4'b0000;
    assign bus.mem_wdata  = (r_size == SZ_B) ? {4{r_wdata[7:0]}} :
                            (r_size == SZ_H) ? {2{r_wdata[15:0]}} : r_wdata;

    lsu_align u_align (
        .rdata       (bus.mem_rdata),
        .off         (off),
        .size        (r_size),
        .is_unsigned (r_uns),
        .data        (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = (r_we || err) ? RESP : WAIT;
            WAIT:    state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= SZ_B;
            r_addr  <= '0;
            r_wdata <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                r_we    <= bus.req_we;
                r_uns   <= bus.req_unsigned;
                r_size  <= bus.req_size;
                r_addr  <= bus.req_addr[MEM_AW+1:0];
                r_wdata <= bus.req_wdata;
            end
            if ((state == ACCESS) && (r_we || err)) begin
                rdata_q <= '0;
                err_q   <= err;
            end
            if (state == WAIT) begin
                rdata_q <= ld_data;
                err_q   <= 1'b0;
            end
        end
    end

endmodule
